alu_seq_unit: RTL

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_unit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: single-issue ALU with a one-cycle path for simple ops and a
// shift-add multiplier that retires one multiplier bit per clock.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for Start; single-cycle ops execute on the accept edge
// S_MUL  | shift-add multiply in progress, cnt_q = multiplier bit index
// S_DONE | result and flags valid, Done pulses for this one cycle
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [3:0]       ALU_Op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  input  logic             NOP_FLAG,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] RZ,
  output logic             CARRY_FLAG,
  output logic             OVERFLOW_FLAG,
  output logic             ZERO_FLAG,
  output logic             NEGATIVE_FLAG,
  output logic             INR_FLAG
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  localparam logic [WIDTH:0] ONE_X    = 1;
  localparam logic [SHW-1:0] CNT_ONE  = 1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [SHW-1:0]     cnt_q;
  logic               nop_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_ok;
  logic [SHW-1:0]     sh_amt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     shr;
  logic signed [WIDTH:0] sra;
  logic               mul_hi_nz;

  // single-cycle ALU: result, carry, overflow and "opcode recognised"
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ok  = 1'b1;
    sh_amt  = RB[SHW-1:0];
    sum     = '0;
    // the extra bit catches the last bit shifted out on either side
    shl     = {1'b0, RA} << sh_amt;
    shr     = {RA, 1'b0} >> sh_amt;
    sra     = $signed({RA, 1'b0}) >>> sh_amt;
    case (ALU_Op)
      OP_ADD: begin
        sum     = {1'b0, RA} + {1'b0, RB};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (RA[WIDTH-1] == RB[WIDTH-1]) && (sum[WIDTH-1] != RA[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, RA} + {1'b0, ~RB} + ONE_X;
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (RA[WIDTH-1] != RB[WIDTH-1]) && (sum[WIDTH-1] != RA[WIDTH-1]);
      end
      OP_INC: begin
        sum     = {1'b0, RA} + ONE_X;
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = !RA[WIDTH-1] && sum[WIDTH-1];
      end
      OP_AND:  alu_res = RA & RB;
      OP_OR:   alu_res = RA | RB;
      OP_XOR:  alu_res = RA ^ RB;
      OP_NOT:  alu_res = ~RA;
      OP_PASS: alu_res = RB;
      OP_SLL: begin
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      OP_SRL: begin
        alu_res = shr[WIDTH:1];
        alu_c   = shr[0];
      end
      OP_SRA: begin
        alu_res = sra[WIDTH:1];
        alu_c   = sra[0];
      end
      OP_MUL:  alu_ok = 1'b1;
      default: alu_ok = 1'b0;
    endcase
  end

  // multiplier step: add the shifted multiplicand when the current bit is set
  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_hi_nz = |acc_d[2*WIDTH-1:WIDTH];
  end

  // state register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = (ALU_Op == OP_MUL) ? S_MUL : S_DONE;
      end
      S_MUL: begin
        Busy = 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // datapath: operand capture, multiplier iteration, result and flag load
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      nop_q         <= 1'b0;
      RZ            <= '0;
      CARRY_FLAG    <= 1'b0;
      OVERFLOW_FLAG <= 1'b0;
      ZERO_FLAG     <= 1'b0;
      NEGATIVE_FLAG <= 1'b0;
      INR_FLAG      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            if (ALU_Op == OP_MUL) begin
              mcand_q  <= {{WIDTH{1'b0}}, RA};
              mplier_q <= RB;
              acc_q    <= '0;
              cnt_q    <= '0;
              nop_q    <= NOP_FLAG;
            end else if (alu_ok) begin
              RZ <= alu_res;
              if (!NOP_FLAG) begin
                CARRY_FLAG    <= alu_c;
                OVERFLOW_FLAG <= alu_v;
                ZERO_FLAG     <= (alu_res == '0);
                NEGATIVE_FLAG <= alu_res[WIDTH-1];
                INR_FLAG      <= 1'b0;
              end
            end else if (!NOP_FLAG) begin
              // unknown opcode leaves RZ and arithmetic flags untouched
              INR_FLAG <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            RZ <= acc_d[WIDTH-1:0];
            if (!nop_q) begin
              CARRY_FLAG    <= mul_hi_nz;
              OVERFLOW_FLAG <= mul_hi_nz;
              ZERO_FLAG     <= (acc_d[WIDTH-1:0] == '0);
              NEGATIVE_FLAG <= acc_d[WIDTH-1];
              INR_FLAG      <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
